// File: rtl/bp_common_pkg.sv
// Shared BedRock message types, processor configuration table and the
// register map for the sacc summation accelerator.
package bp_common_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef struct packed {
    int unsigned paddr_width;
    int unsigned lce_id_width;
    int unsigned cce_block_width;
  } bp_proc_param_s;

  localparam int unsigned paddr_width_gp     = 40;
  localparam int unsigned lce_id_width_gp    = 4;
  localparam int unsigned cce_block_width_gp = 512;

  function automatic bp_proc_param_s bp_get_proc_param(input bp_params_e cfg);
    bp_proc_param_s p;
    case (cfg)
      default: p = '{paddr_width: paddr_width_gp,
                     lce_id_width: lce_id_width_gp,
                     cce_block_width: cce_block_width_gp};
    endcase
    return p;
  endfunction

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'h0,
    e_bedrock_mem_wr    = 4'h1,
    e_bedrock_mem_uc_rd = 4'h2,
    e_bedrock_mem_uc_wr = 4'h3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'h0,
    e_bedrock_msg_size_2  = 3'h1,
    e_bedrock_msg_size_4  = 3'h2,
    e_bedrock_msg_size_8  = 3'h3,
    e_bedrock_msg_size_16 = 3'h4,
    e_bedrock_msg_size_32 = 3'h5,
    e_bedrock_msg_size_64 = 3'h6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
  } bp_bedrock_cce_mem_payload_s;

  typedef struct packed {
    bp_bedrock_cce_mem_payload_s payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_cce_mem_header_s;

  typedef enum logic [1:0] {
    e_sacc_vdp      = 2'd0,
    e_sacc_loopback = 2'd1,
    e_sacc_sum      = 2'd2
  } bp_sacc_type_e;

  localparam logic [7:0] sacc_sum_csr_src_gp    = 8'h00;
  localparam logic [7:0] sacc_sum_csr_len_gp    = 8'h08;
  localparam logic [7:0] sacc_sum_csr_start_gp  = 8'h10;
  localparam logic [7:0] sacc_sum_csr_status_gp = 8'h18;
  localparam logic [7:0] sacc_sum_csr_result_gp = 8'h20;

endpackage

// File: rtl/bp_sacc_sum.sv
// Summation accelerator: CSR slave plus a memory master that sums LEN
// consecutive 64-bit words starting at SRC, one uncached read at a time.
module bp_sacc_sum
  import bp_common_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
  , localparam bp_proc_param_s proc_param_lp = bp_get_proc_param(bp_params_p)
  , localparam int unsigned paddr_width_p     = proc_param_lp.paddr_width
  , localparam int unsigned lce_id_width_p    = proc_param_lp.lce_id_width
  , localparam int unsigned cce_block_width_p = proc_param_lp.cce_block_width
  )
  (input  logic                             clk_i
  ,input  logic                             reset_i
  ,input  logic [lce_id_width_p-1:0]        lce_id_i
  ,input  bp_bedrock_cce_mem_header_s       io_cmd_header_i
  ,input  logic [cce_block_width_p-1:0]     io_cmd_data_i
  ,input  logic                             io_cmd_v_i
  ,output logic                             io_cmd_ready_o
  ,output bp_bedrock_cce_mem_header_s       io_resp_header_o
  ,output logic [cce_block_width_p-1:0]     io_resp_data_o
  ,output logic                             io_resp_v_o
  ,input  logic                             io_resp_yumi_i
  ,output bp_bedrock_cce_mem_header_s       io_cmd_header_o
  ,output logic [cce_block_width_p-1:0]     io_cmd_data_o
  ,output logic                             io_cmd_v_o
  ,input  logic                             io_cmd_yumi_i
  ,input  bp_bedrock_cce_mem_header_s       io_resp_header_i
  ,input  logic [cce_block_width_p-1:0]     io_resp_data_i
  ,input  logic                             io_resp_v_i
  ,output logic                             io_resp_ready_o
  );

  localparam int unsigned word_width_lp = 64;

  typedef enum logic {S_READY, S_RESP} slave_state_e;
  typedef enum logic [1:0] {M_IDLE, M_SEND, M_WAIT} master_state_e;

  slave_state_e                     r_s_state;
  master_state_e                    r_m_state;
  logic [word_width_lp-1:0]         r_src, r_len, r_result, r_count;
  logic [paddr_width_p-1:0]         r_ptr;
  logic                             r_busy, r_done;
  logic                             r_resp_v, r_cmd_v;
  bp_bedrock_cce_mem_header_s       r_resp_header, r_cmd_header;
  logic [cce_block_width_p-1:0]     r_resp_data;

  logic                             w_accept, w_is_wr, w_start, w_resp_fire, w_last;
  logic [7:0]                       w_offset;
  logic [word_width_lp-1:0]         w_wdata, w_rdata, w_resp_word;
  logic [paddr_width_p-1:0]         w_ptr_next;
  bp_bedrock_cce_mem_header_s       w_cmd_header;
  logic                             w_unused;

  assign io_cmd_ready_o   = (r_s_state == S_READY) & ~reset_i;
  assign io_resp_ready_o  = (r_m_state == M_IDLE) | (r_m_state == M_WAIT);
  assign io_resp_v_o      = r_resp_v;
  assign io_resp_header_o = r_resp_header;
  assign io_resp_data_o   = r_resp_data;
  assign io_cmd_v_o       = r_cmd_v;
  assign io_cmd_header_o  = r_cmd_header;
  assign io_cmd_data_o    = '0;

  assign w_accept    = io_cmd_v_i & io_cmd_ready_o;
  assign w_offset    = io_cmd_header_i.addr[7:0];
  assign w_is_wr     = (io_cmd_header_i.msg_type == e_bedrock_mem_uc_wr)
                     | (io_cmd_header_i.msg_type == e_bedrock_mem_wr);
  assign w_wdata     = io_cmd_data_i[word_width_lp-1:0];
  assign w_start     = w_accept & w_is_wr & (w_offset == sacc_sum_csr_start_gp)
                     & (r_m_state == M_IDLE);
  assign w_resp_fire = io_resp_v_i & (r_m_state == M_WAIT);
  assign w_resp_word = io_resp_data_i[word_width_lp-1:0];
  assign w_last      = (r_count == word_width_lp'(1));
  assign w_ptr_next  = r_ptr + paddr_width_p'(8);

  assign w_unused = &{1'b0, io_resp_header_i, io_resp_data_i[cce_block_width_p-1:word_width_lp],
                      io_cmd_data_i[cce_block_width_p-1:word_width_lp]};

  // Read mux samples pre-update register values, so a read that lands on the
  // final accumulation edge returns the old RESULT/STATUS.
  always_comb begin
    w_rdata = '0;
    if (!w_is_wr) begin
      case (w_offset)
        sacc_sum_csr_src_gp:    w_rdata = r_src;
        sacc_sum_csr_len_gp:    w_rdata = r_len;
        sacc_sum_csr_status_gp: w_rdata = {62'b0, r_done, r_busy};
        sacc_sum_csr_result_gp: w_rdata = r_result;
        default:                w_rdata = '0;
      endcase
    end
  end

  // Next outbound read: first address comes from SRC, later ones from ptr+8.
  always_comb begin
    w_cmd_header                = '0;
    w_cmd_header.msg_type       = e_bedrock_mem_uc_rd;
    w_cmd_header.size           = e_bedrock_msg_size_8;
    w_cmd_header.payload.lce_id = lce_id_i;
    w_cmd_header.addr           = (r_m_state == M_IDLE) ? r_src[paddr_width_p-1:0] : w_ptr_next;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s_state     <= S_READY;
      r_resp_v      <= 1'b0;
      r_resp_header <= '0;
      r_resp_data   <= '0;
      r_src         <= '0;
      r_len         <= '0;
    end else begin
      case (r_s_state)
        S_READY: if (w_accept) begin
          r_resp_v      <= 1'b1;
          r_resp_header <= io_cmd_header_i;
          r_resp_data   <= cce_block_width_p'(w_rdata);
          r_s_state     <= S_RESP;
          if (w_is_wr && !r_busy && (w_offset == sacc_sum_csr_src_gp)) r_src <= w_wdata;
          if (w_is_wr && !r_busy && (w_offset == sacc_sum_csr_len_gp)) r_len <= w_wdata;
        end
        S_RESP: if (io_resp_yumi_i) begin
          r_resp_v  <= 1'b0;
          r_s_state <= S_READY;
        end
        default: r_s_state <= S_READY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_m_state    <= M_IDLE;
      r_cmd_v      <= 1'b0;
      r_cmd_header <= '0;
      r_result     <= '0;
      r_ptr        <= '0;
      r_count      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_m_state)
        M_IDLE: if (w_start) begin
          r_result <= '0;
          r_ptr    <= r_src[paddr_width_p-1:0];
          r_count  <= r_len;
          r_done   <= (r_len == '0);
          if (r_len != '0) begin
            r_busy       <= 1'b1;
            r_cmd_v      <= 1'b1;
            r_cmd_header <= w_cmd_header;
            r_m_state    <= M_SEND;
          end
        end
        M_SEND: if (io_cmd_yumi_i) begin
          r_cmd_v   <= 1'b0;
          r_m_state <= M_WAIT;
        end
        M_WAIT: if (w_resp_fire) begin
          r_result <= r_result + w_resp_word;
          r_ptr    <= w_ptr_next;
          r_count  <= r_count - word_width_lp'(1);
          if (w_last) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_m_state <= M_IDLE;
          end else begin
            r_cmd_v      <= 1'b1;
            r_cmd_header <= w_cmd_header;
            r_m_state    <= M_SEND;
          end
        end
        default: r_m_state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_sacc_sum.sv
// Scoreboard bench for bp_sacc_sum: CSR responses and outbound read
// addresses are queued as expectations and compared as the DUT produces them.
module tb_bp_sacc_sum;
  import bp_common_pkg::*;

  localparam int unsigned BLK = cce_block_width_gp;
  localparam int unsigned PA  = paddr_width_gp;

  logic                       clk_i = 1'b0;
  logic                       reset_i;
  logic [lce_id_width_gp-1:0] lce_id_i;
  bp_bedrock_cce_mem_header_s io_cmd_header_i, io_resp_header_o, io_cmd_header_o, io_resp_header_i;
  logic [BLK-1:0]             io_cmd_data_i, io_resp_data_o, io_cmd_data_o, io_resp_data_i;
  logic io_cmd_v_i, io_cmd_ready_o, io_resp_v_o, io_resp_yumi_i;
  logic io_cmd_v_o, io_cmd_yumi_i, io_resp_v_i, io_resp_ready_o;

  int errors = 0;
  int checks = 0;
  logic [63:0]   exp_rd_q[$];
  logic [PA-1:0] exp_addr_q[$];
  logic [63:0]   mem_q[$];

  always #5 clk_i = ~clk_i;

  bp_sacc_sum dut (
    .clk_i(clk_i), .reset_i(reset_i), .lce_id_i(lce_id_i),
    .io_cmd_header_i(io_cmd_header_i), .io_cmd_data_i(io_cmd_data_i),
    .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_resp_header_o(io_resp_header_o), .io_resp_data_o(io_resp_data_o),
    .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .io_cmd_header_o(io_cmd_header_o), .io_cmd_data_o(io_cmd_data_o),
    .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
    .io_resp_header_i(io_resp_header_i), .io_resp_data_i(io_resp_data_i),
    .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o));

  // One CSR transaction; hold keeps yumi low that many cycles before consuming.
  task automatic csr(input bit wr, input logic [7:0] off, input logic [63:0] wdata,
                     input logic [63:0] exp, input int hold, input string name);
    bp_bedrock_cce_mem_header_s hdr, held_hdr;
    logic [BLK-1:0] held_data;
    logic [63:0] e;
    int n;
    hdr = '0;
    hdr.msg_type = wr ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
    hdr.addr = {32'h0000_0020, off};
    hdr.size = e_bedrock_msg_size_8;
    hdr.payload.lce_id = 4'h3;
    exp_rd_q.push_back(wr ? 64'h0 : exp);
    @(negedge clk_i);
    io_cmd_header_i = hdr; io_cmd_data_i = BLK'(wdata); io_cmd_v_i = 1'b1;
    n = 0;
    while (!io_cmd_ready_o && n < 50) begin @(negedge clk_i); n++; end
    checks++;
    if (io_cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s accept: ready=%b, required 1", name, io_cmd_ready_o);
    end
    @(negedge clk_i);
    io_cmd_v_i = 1'b0; io_cmd_header_i = '0; io_cmd_data_i = '0;
    n = 0;
    while (!io_resp_v_o && n < 50) begin @(negedge clk_i); n++; end
    held_hdr = io_resp_header_o; held_data = io_resp_data_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      checks++;
      if (io_resp_v_o !== 1'b1 || io_resp_header_o !== held_hdr || io_resp_data_o !== held_data) begin
        errors++; $display("FAIL %s hold: resp_v=%b data=%h, required stable", name, io_resp_v_o, io_resp_data_o[63:0]);
      end
    end
    e = exp_rd_q.pop_front();
    checks++;
    if (io_resp_v_o !== 1'b1 || io_resp_data_o !== BLK'(e)) begin
      errors++; $display("FAIL %s data: v=%b got %h, required %h", name, io_resp_v_o, io_resp_data_o, BLK'(e));
    end
    checks++;
    if (io_resp_header_o !== hdr) begin
      errors++; $display("FAIL %s echo: got %h, required %h", name, io_resp_header_o, hdr);
    end
    io_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
    checks++;
    if (io_resp_v_o !== 1'b0) begin
      errors++; $display("FAIL %s drop: resp_v=%b, required 0", name, io_resp_v_o);
    end
  endtask

  // Memory side: answers n reads, checking each against the address queue.
  task automatic serve_reads(input int n, input int stall, input string name);
    bp_bedrock_cce_mem_header_s held;
    logic [PA-1:0] ea;
    int c;
    for (int k = 0; k < n; k++) begin
      c = 0;
      while (!io_cmd_v_o && c < 100) begin @(negedge clk_i); c++; end
      checks++;
      if (io_cmd_v_o !== 1'b1) begin
        errors++; $display("FAIL %s read%0d: cmd_v=%b, required 1", name, k, io_cmd_v_o);
        return;
      end
      ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : '1;
      checks++;
      if (io_cmd_header_o.addr !== ea || io_cmd_header_o.msg_type !== e_bedrock_mem_uc_rd ||
          io_cmd_header_o.size !== e_bedrock_msg_size_8 || io_cmd_header_o.payload.lce_id !== lce_id_i ||
          io_cmd_data_o !== '0) begin
        errors++; $display("FAIL %s read%0d hdr: got addr=%h type=%0d size=%0d lce=%0d, required addr=%h type=2 size=3 lce=%0d",
                           name, k, io_cmd_header_o.addr, io_cmd_header_o.msg_type, io_cmd_header_o.size,
                           io_cmd_header_o.payload.lce_id, ea, lce_id_i);
      end
      held = io_cmd_header_o;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk_i);
        checks++;
        if (io_cmd_v_o !== 1'b1 || io_cmd_header_o !== held) begin
          errors++; $display("FAIL %s read%0d stall: cmd_v=%b addr=%h, required stable", name, k, io_cmd_v_o, io_cmd_header_o.addr);
        end
      end
      io_cmd_yumi_i = 1'b1;
      @(negedge clk_i);
      io_cmd_yumi_i = 1'b0;
      checks++;
      if (io_cmd_v_o !== 1'b0 || io_resp_ready_o !== 1'b1) begin
        errors++; $display("FAIL %s read%0d outstanding: cmd_v=%b resp_ready=%b, required 0/1", name, k, io_cmd_v_o, io_resp_ready_o);
      end
      io_resp_data_i = {{(BLK-64){1'b1}}, mem_q.pop_front()};
      io_resp_v_i = 1'b1;
      @(negedge clk_i);
      io_resp_v_i = 1'b0;
    end
  endtask

  task automatic setup_job(input logic [63:0] src, input logic [63:0] len, input string name);
    for (int i = 0; i < int'(len); i++) exp_addr_q.push_back(src[PA-1:0] + PA'(8 * i));
    csr(1'b1, sacc_sum_csr_src_gp, src, 64'h0, 0, {name, "_src"});
    csr(1'b1, sacc_sum_csr_len_gp, len, 64'h0, 0, {name, "_len"});
    csr(1'b1, sacc_sum_csr_start_gp, 64'h1, 64'h0, 0, {name, "_start"});
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (io_cmd_ready_o !== 1'b0 || io_resp_v_o !== 1'b0 || io_cmd_v_o !== 1'b0 ||
        io_resp_data_o !== '0 || io_cmd_header_o !== '0) begin
      errors++; $display("FAIL reset_outputs: ready=%b resp_v=%b cmd_v=%b, required 0/0/0 with zero data",
                         io_cmd_ready_o, io_resp_v_o, io_cmd_v_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (io_cmd_ready_o !== 1'b1 || io_resp_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: cmd_ready=%b resp_ready=%b, required 1/1", io_cmd_ready_o, io_resp_ready_o);
    end
    csr(1'b0, sacc_sum_csr_status_gp, 64'h0, 64'h0, 0, "reset_status");
    csr(1'b0, sacc_sum_csr_result_gp, 64'h0, 64'h0, 0, "reset_result");
    csr(1'b1, 8'h30, 64'hdead, 64'h0, 0, "unmapped_wr");
    csr(1'b0, sacc_sum_csr_src_gp, 64'h0, 64'h0, 0, "reset_src");
    csr(1'b0, 8'h30, 64'h0, 64'h0, 0, "unmapped_rd");
  endtask

  // Four words, with a RESULT read landing on the final accumulation edge.
  task automatic test_basic_sum();
    int c;
    mem_q.push_back(64'd1); mem_q.push_back(64'd2); mem_q.push_back(64'd3);
    setup_job(64'h0000_0000_8000_0000, 64'd4, "basic");
    csr(1'b0, sacc_sum_csr_src_gp, 64'h0, 64'h0000_0000_8000_0000, 0, "basic_src_rd");
    csr(1'b0, sacc_sum_csr_start_gp, 64'h0, 64'h0, 0, "start_rd");
    serve_reads(3, 0, "basic");
    c = 0;
    while (!io_cmd_v_o && c < 100) begin @(negedge clk_i); c++; end
    checks++;
    if (io_cmd_v_o !== 1'b1 || io_cmd_header_o.addr !== exp_addr_q[0]) begin
      errors++; $display("FAIL basic_last_read: cmd_v=%b addr=%h, required 1 addr=%h", io_cmd_v_o, io_cmd_header_o.addr, exp_addr_q[0]);
    end
    void'(exp_addr_q.pop_front());
    io_cmd_yumi_i = 1'b1;
    @(negedge clk_i);
    io_cmd_yumi_i = 1'b0;
    fork
      csr(1'b0, sacc_sum_csr_result_gp, 64'h0, 64'd6, 0, "coincident_result");
      begin
        @(negedge clk_i);
        io_resp_data_i = BLK'(64'd4); io_resp_v_i = 1'b1;
        @(negedge clk_i);
        io_resp_v_i = 1'b0;
      end
    join
    csr(1'b0, sacc_sum_csr_result_gp, 64'h0, 64'd10, 0, "basic_result");
    csr(1'b0, sacc_sum_csr_status_gp, 64'h0, 64'h2, 0, "basic_status");
  endtask

  task automatic test_zero_len();
    setup_job(64'h0000_0000_9000_0000, 64'd0, "zero");
    checks++;
    if (io_cmd_v_o !== 1'b0) begin
      errors++; $display("FAIL zero_no_read: cmd_v=%b, required 0", io_cmd_v_o);
    end
    csr(1'b0, sacc_sum_csr_status_gp, 64'h0, 64'h2, 0, "zero_status");
    csr(1'b0, sacc_sum_csr_result_gp, 64'h0, 64'h0, 0, "zero_result");
  endtask

  // Sum wraps mod 2^64 and the pointer wraps at the top of the address space.
  task automatic test_wrap();
    mem_q.push_back(64'hFFFF_FFFF_FFFF_FFFF); mem_q.push_back(64'd2);
    setup_job(64'h0000_00FF_FFFF_FFF8, 64'd2, "wrap");
    serve_reads(2, 0, "wrap");
    csr(1'b0, sacc_sum_csr_result_gp, 64'h0, 64'd1, 0, "wrap_result");
  endtask

  task automatic test_busy_write();
    mem_q.push_back(64'd5); mem_q.push_back(64'd6); mem_q.push_back(64'd7);
    setup_job(64'h0000_0000_0000_2000, 64'd3, "busy");
    fork
      serve_reads(3, 4, "busy");
      begin
        csr(1'b0, sacc_sum_csr_status_gp, 64'h0, 64'h1, 0, "busy_status");
        csr(1'b1, sacc_sum_csr_len_gp, 64'd9, 64'h0, 0, "busy_len_wr");
        csr(1'b1, sacc_sum_csr_src_gp, 64'h9999, 64'h0, 0, "busy_src_wr");
      end
    join
    repeat (4) @(negedge clk_i);
    checks++;
    if (io_cmd_v_o !== 1'b0) begin
      errors++; $display("FAIL busy_extra_read: cmd_v=%b, required 0", io_cmd_v_o);
    end
    csr(1'b0, sacc_sum_csr_len_gp, 64'h0, 64'd3, 0, "busy_len_rd");
    csr(1'b0, sacc_sum_csr_src_gp, 64'h0, 64'h2000, 0, "busy_src_rd");
    csr(1'b0, sacc_sum_csr_result_gp, 64'h0, 64'd18, 0, "busy_result");
  endtask

  task automatic test_stall();
    mem_q.push_back(64'h100); mem_q.push_back(64'h23);
    setup_job(64'h0000_0000_0000_4000, 64'd2, "stall");
    serve_reads(2, 5, "stall");
    csr(1'b0, sacc_sum_csr_result_gp, 64'h0, 64'h123, 5, "stall_result");
    csr(1'b0, sacc_sum_csr_status_gp, 64'h0, 64'h2, 5, "stall_status");
  endtask

  task automatic test_reset_mid();
    int c;
    setup_job(64'h0000_0000_0000_3000, 64'd2, "mid");
    exp_addr_q.delete();
    c = 0;
    while (!io_cmd_v_o && c < 100) begin @(negedge clk_i); c++; end
    io_cmd_yumi_i = 1'b1;
    @(negedge clk_i);
    io_cmd_yumi_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (io_cmd_ready_o !== 1'b0 || io_cmd_v_o !== 1'b0 || io_resp_v_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: ready=%b cmd_v=%b resp_v=%b, required 0/0/0", io_cmd_ready_o, io_cmd_v_o, io_resp_v_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    io_resp_data_i = BLK'(64'h55); io_resp_v_i = 1'b1;
    checks++;
    if (io_resp_ready_o !== 1'b1) begin
      errors++; $display("FAIL mid_drain_ready: resp_ready=%b, required 1", io_resp_ready_o);
    end
    @(negedge clk_i);
    io_resp_v_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (io_cmd_v_o !== 1'b0) begin
      errors++; $display("FAIL mid_no_read: cmd_v=%b, required 0", io_cmd_v_o);
    end
    csr(1'b0, sacc_sum_csr_src_gp, 64'h0, 64'h0, 0, "mid_src");
    csr(1'b0, sacc_sum_csr_len_gp, 64'h0, 64'h0, 0, "mid_len");
    csr(1'b0, sacc_sum_csr_status_gp, 64'h0, 64'h0, 0, "mid_status");
    csr(1'b0, sacc_sum_csr_result_gp, 64'h0, 64'h0, 0, "mid_result");
  endtask

  initial begin
    reset_i = 1'b1; lce_id_i = 4'h5;
    io_cmd_header_i = '0; io_cmd_data_i = '0; io_cmd_v_i = 1'b0; io_resp_yumi_i = 1'b0;
    io_cmd_yumi_i = 1'b0; io_resp_header_i = '0; io_resp_data_i = '0; io_resp_v_i = 1'b0;
    test_reset();
    test_basic_sum();
    test_zero_len();
    test_wrap();
    test_busy_write();
    test_stall();
    test_reset_mid();
    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
